// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-stage MIPS core: default widths,
// control-bundle bit layout, and the ID/EX stage state encoding.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CTRL_W_DEF = 8;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_LSB = 5;
    localparam int CTRL_ALU_OP_MSB = 7;

    // state     | meaning
    // S_RUN     | normal flow, capture ID every unstalled cycle
    // S_HAZ     | one load-use bubble issued, capture the held instruction next
    typedef enum logic {
        S_RUN = 1'b0,
        S_HAZ = 1'b1
    } idex_state_e;

    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2
    } idex_act_e;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Combinational load-use compare between the EX entry and the instruction in ID.
// Also used by the ID branch-compare path, so it carries no state.
module id_ex_hazard_detect #(
    parameter int ADDR_W = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [ADDR_W-1:0] ex_rd_addr_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_addr_i,
    input  logic [ADDR_W-1:0] id_rt_addr_i,
    output logic              hazard_o
);

    logic src_match;

    // rt is compared even for formats that do not read it; a spurious stall is harmless
    assign src_match = (id_rs_addr_i == ex_rd_addr_i) || (id_rt_addr_i == ex_rd_addr_i);

    assign hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != '0)
                      && id_valid_i && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// flush and downstream stall. Optional perf counters: define IDEX_PERF_CNT_EN.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_addr_i,
    input  logic [ADDR_W-1:0] id_rt_addr_i,
    input  logic [ADDR_W-1:0] id_rd_addr_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              wb_reg_write_i,
    input  logic [ADDR_W-1:0] wb_rd_addr_i,
    input  logic [DATA_W-1:0] wb_rd_data_i,
    input  logic              flush_i,
    input  logic              ex_stall_i,
    output logic              id_stall_o,
    output logic              ex_valid_o,
    output logic [ADDR_W-1:0] ex_rs_addr_o,
    output logic [ADDR_W-1:0] ex_rt_addr_o,
    output logic [ADDR_W-1:0] ex_rd_addr_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
`ifdef IDEX_PERF_CNT_EN
    output logic [15:0]       perf_bubble_cnt_o,
    output logic [15:0]       perf_flush_cnt_o,
`endif
    output logic [CTRL_W-1:0] ex_ctrl_o
);

    idex_state_e state_q, state_d;
    idex_act_e   act;
    logic        hazard;
    logic        wb_hit_rs, wb_hit_rt;
    logic [DATA_W-1:0] rs_data_byp, rt_data_byp;

    id_ex_hazard_detect #(.ADDR_W(ADDR_W)) u_hazard (
        .ex_valid_i    (ex_valid_o),
        .ex_mem_read_i (ex_ctrl_o[CTRL_MEM_READ]),
        .ex_rd_addr_i  (ex_rd_addr_o),
        .id_valid_i    (id_valid_i),
        .id_rs_addr_i  (id_rs_addr_i),
        .id_rt_addr_i  (id_rt_addr_i),
        .hazard_o      (hazard)
    );

    // Register 0 is hardwired, so a write to it must never be forwarded
    assign wb_hit_rs = wb_reg_write_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs_addr_i);
    assign wb_hit_rt = wb_reg_write_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rt_addr_i);

    assign rs_data_byp = wb_hit_rs ? wb_rd_data_i : id_rs_data_i;
    assign rt_data_byp = wb_hit_rt ? wb_rd_data_i : id_rt_data_i;

    always_comb begin
        state_d    = state_q;
        act        = ACT_CAPTURE;
        id_stall_o = 1'b0;
        if (flush_i) begin
            act     = ACT_BUBBLE;
            state_d = S_RUN;
        end else if (ex_stall_i) begin
            act        = ACT_HOLD;
            id_stall_o = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (hazard) begin
                        act        = ACT_BUBBLE;
                        id_stall_o = 1'b1;
                        state_d    = S_HAZ;
                    end
                end
                S_HAZ:   state_d = S_RUN;
                default: state_d = S_RUN;
            endcase
        end
        if (rst_i) begin
            id_stall_o = 1'b0;
            state_d    = S_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_o   <= 1'b0;
            ex_rs_addr_o <= '0;
            ex_rt_addr_o <= '0;
            ex_rd_addr_o <= '0;
            ex_rs_data_o <= '0;
            ex_rt_data_o <= '0;
            ex_imm_o     <= '0;
            ex_ctrl_o    <= '0;
        end else begin
            case (act)
                ACT_CAPTURE: begin
                    // Invalid ID slots become zeroed bubbles so EX never sees stale fields
                    ex_valid_o   <= id_valid_i;
                    ex_rs_addr_o <= id_valid_i ? id_rs_addr_i : '0;
                    ex_rt_addr_o <= id_valid_i ? id_rt_addr_i : '0;
                    ex_rd_addr_o <= id_valid_i ? id_rd_addr_i : '0;
                    ex_rs_data_o <= id_valid_i ? rs_data_byp  : '0;
                    ex_rt_data_o <= id_valid_i ? rt_data_byp  : '0;
                    ex_imm_o     <= id_valid_i ? id_imm_i     : '0;
                    ex_ctrl_o    <= id_valid_i ? id_ctrl_i    : '0;
                end
                ACT_BUBBLE: begin
                    ex_valid_o   <= 1'b0;
                    ex_rs_addr_o <= '0;
                    ex_rt_addr_o <= '0;
                    ex_rd_addr_o <= '0;
                    ex_rs_data_o <= '0;
                    ex_rt_data_o <= '0;
                    ex_imm_o     <= '0;
                    ex_ctrl_o    <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic bubble_evt, flush_evt;

    assign bubble_evt = !flush_i && !ex_stall_i && (state_q == S_RUN) && hazard;
    assign flush_evt  = flush_i && id_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_bubble_cnt_o <= '0;
            perf_flush_cnt_o  <= '0;
        end else begin
            if (bubble_evt && (perf_bubble_cnt_o != 16'hFFFF))
                perf_bubble_cnt_o <= perf_bubble_cnt_o + 16'd1;
            if (flush_evt && (perf_flush_cnt_o != 16'hFFFF))
                perf_flush_cnt_o <= perf_flush_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage, checked against a spec-level model.
// Perf counter ports are connected and checked when IDEX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [7:0]  id_ctrl_i;
    logic        wb_reg_write_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_data_i;
    logic        flush_i, ex_stall_i;
    logic        id_stall_o, ex_valid_o;
    logic [4:0]  ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;
    logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [7:0]  ex_ctrl_o;
`ifdef IDEX_PERF_CNT_EN
    logic [15:0] perf_bubble_cnt_o, perf_flush_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs_addr_i   (id_rs_addr_i),
        .id_rt_addr_i   (id_rt_addr_i),
        .id_rd_addr_i   (id_rd_addr_i),
        .id_rs_data_i   (id_rs_data_i),
        .id_rt_data_i   (id_rt_data_i),
        .id_imm_i       (id_imm_i),
        .id_ctrl_i      (id_ctrl_i),
        .wb_reg_write_i (wb_reg_write_i),
        .wb_rd_addr_i   (wb_rd_addr_i),
        .wb_rd_data_i   (wb_rd_data_i),
        .flush_i        (flush_i),
        .ex_stall_i     (ex_stall_i),
        .id_stall_o     (id_stall_o),
        .ex_valid_o     (ex_valid_o),
        .ex_rs_addr_o   (ex_rs_addr_o),
        .ex_rt_addr_o   (ex_rt_addr_o),
        .ex_rd_addr_o   (ex_rd_addr_o),
        .ex_rs_data_o   (ex_rs_data_o),
        .ex_rt_data_o   (ex_rt_data_o),
        .ex_imm_o       (ex_imm_o),
`ifdef IDEX_PERF_CNT_EN
        .perf_bubble_cnt_o (perf_bubble_cnt_o),
        .perf_flush_cnt_o  (perf_flush_cnt_o),
`endif
        .ex_ctrl_o      (ex_ctrl_o)
    );

    // Reference model: the expected EX entry plus a flag for "a load-use bubble was just issued"
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [7:0]  m_ctrl;
    bit          m_bubbled;
    int          m_bubbles, m_flushes;
    bit          exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_rsd = '0; m_rtd = '0; m_imm = '0; m_ctrl = '0;
    endtask

    function automatic bit load_use();
        return m_valid && m_ctrl[1] && (m_rd != 0) && id_valid_i &&
               (id_rs_addr_i == m_rd || id_rt_addr_i == m_rd);
    endfunction

    // One clock: check the combinational stall, advance the model, check the EX entry
    task automatic step();
        bit haz;
        #1;
        haz = load_use() && !m_bubbled;
        if (rst_i)           exp_stall = 0;
        else if (flush_i)    exp_stall = 0;
        else if (ex_stall_i) exp_stall = 1;
        else                 exp_stall = haz;
        chk("id_stall", 32'(id_stall_o), 32'(exp_stall));

        if (rst_i) begin
            model_clear(); m_bubbled = 0; m_bubbles = 0; m_flushes = 0;
        end else if (flush_i) begin
            if (id_valid_i) m_flushes++;
            model_clear(); m_bubbled = 0;
        end else if (ex_stall_i) begin
            // entry frozen, no bypass refresh
        end else if (haz) begin
            m_bubbles++;
            model_clear(); m_bubbled = 1;
        end else begin
            m_bubbled = 0;
            if (id_valid_i) begin
                m_valid = 1; m_rs = id_rs_addr_i; m_rt = id_rt_addr_i; m_rd = id_rd_addr_i;
                m_imm = id_imm_i; m_ctrl = id_ctrl_i;
                m_rsd = (wb_reg_write_i && wb_rd_addr_i != 0 && wb_rd_addr_i == id_rs_addr_i)
                        ? wb_rd_data_i : id_rs_data_i;
                m_rtd = (wb_reg_write_i && wb_rd_addr_i != 0 && wb_rd_addr_i == id_rt_addr_i)
                        ? wb_rd_data_i : id_rt_data_i;
            end else begin
                model_clear();
            end
        end

        @(posedge clk_i);
        #1;
        chk("ex_valid", 32'(ex_valid_o), 32'(m_valid));
        chk("ex_ctrl",  32'(ex_ctrl_o),  32'(m_ctrl));
        if (m_valid) begin
            chk("ex_rs_addr", 32'(ex_rs_addr_o), 32'(m_rs));
            chk("ex_rt_addr", 32'(ex_rt_addr_o), 32'(m_rt));
            chk("ex_rd_addr", 32'(ex_rd_addr_o), 32'(m_rd));
            chk("ex_rs_data", ex_rs_data_o, m_rsd);
            chk("ex_rt_data", ex_rt_data_o, m_rtd);
            chk("ex_imm",     ex_imm_o,     m_imm);
        end
`ifdef IDEX_PERF_CNT_EN
        chk("perf_bubble", 32'(perf_bubble_cnt_o), 32'(m_bubbles > 65535 ? 65535 : m_bubbles));
        chk("perf_flush",  32'(perf_flush_cnt_o),  32'(m_flushes > 65535 ? 65535 : m_flushes));
`endif
        @(negedge clk_i);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [7:0] ctrl);
        id_valid_i = v; id_rs_addr_i = rs; id_rt_addr_i = rt; id_rd_addr_i = rd;
        id_rs_data_i = rsd; id_rt_data_i = rtd; id_ctrl_i = ctrl;
        id_imm_i = {27'd0, rd} ^ 32'h0000_1000;
    endtask

    initial begin
        rst_i = 1; flush_i = 0; ex_stall_i = 0;
        wb_reg_write_i = 0; wb_rd_addr_i = '0; wb_rd_data_i = '0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        model_clear(); m_bubbled = 0; m_bubbles = 0; m_flushes = 0;
        @(negedge clk_i);

        // Reset for two cycles; outputs must be all zero
        step(); step();
        chk("rst_valid", 32'(ex_valid_o), 32'd0);
        chk("rst_rs_data", ex_rs_data_o, 32'd0);
        chk("rst_stall", 32'(id_stall_o), 32'd0);
        rst_i = 0;

        // Plain capture
        set_id(1, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 8'h81);
        step();
        chk("cap_valid", 32'(ex_valid_o), 32'd1);
        chk("cap_rs", ex_rs_data_o, 32'h11);
        chk("cap_rt", ex_rt_data_o, 32'h22);

        // Writeback bypass, then r0 must not bypass
        set_id(1, 5'd5, 5'd6, 5'd10, 32'hDEAD, 32'h66, 8'h01);
        wb_reg_write_i = 1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'h1234;
        step();
        chk("byp_rs", ex_rs_data_o, 32'h1234);
        set_id(1, 5'd0, 5'd6, 5'd10, 32'hDEAD, 32'h66, 8'h01);
        wb_rd_addr_i = 5'd0;
        step();
        chk("byp_r0", ex_rs_data_o, 32'hDEAD);
        // Both sources from the same writeback
        set_id(1, 5'd8, 5'd8, 5'd11, 32'h1, 32'h2, 8'h01);
        wb_rd_addr_i = 5'd8; wb_rd_data_i = 32'hCAFE;
        step();
        chk("byp_both", ex_rt_data_o, 32'hCAFE);
        wb_reg_write_i = 0;

        // Load-use: load r7, then consumer of r7 via rt
        set_id(1, 5'd1, 5'd2, 5'd7, 32'h5, 32'h6, 8'h03);
        step();
        set_id(1, 5'd1, 5'd7, 5'd12, 32'h77, 32'h88, 8'h01);
        step();
        chk("lu_bubble_ctrl", 32'(ex_ctrl_o), 32'd0);
        chk("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
        step();
        chk("lu_capture_valid", 32'(ex_valid_o), 32'd1);
        chk("lu_capture_rt", 32'(ex_rt_addr_o), 32'd7);
        chk("lu_one_bubble", 32'(m_bubbles), 32'd1);

        // Flush on the hazard cycle: bubble, no stall, no second bubble
        set_id(1, 5'd1, 5'd2, 5'd7, 32'h5, 32'h6, 8'h03);
        step();
        set_id(1, 5'd7, 5'd3, 5'd13, 32'h9, 32'hA, 8'h01);
        flush_i = 1;
        step();
        chk("fl_stall", 32'(exp_stall), 32'd0);
        chk("fl_valid", 32'(ex_valid_o), 32'd0);
        flush_i = 0;
        set_id(1, 5'd14, 5'd15, 5'd16, 32'hB, 32'hC, 8'h01);
        step();
        chk("fl_next_valid", 32'(ex_valid_o), 32'd1);

        // Downstream stall: three held cycles with changing ID, capture on the fourth
        ex_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5'(i + 17), 5'(i + 20), 5'(i + 23), 32'(i + 100), 32'(i + 200), 8'h01);
            step();
            chk("st_hold_rs", ex_rs_data_o, 32'hB);
        end
        ex_stall_i = 0;
        step();
        chk("st_release_rs", ex_rs_data_o, 32'd102);

        // Randomised traffic on a small register window to provoke hazards and bypasses
        for (int n = 0; n < 600; n++) begin
            rst_i      = ($urandom_range(63) == 0);
            flush_i    = ($urandom_range(7) == 0);
            ex_stall_i = ($urandom_range(5) == 0);
            set_id(($urandom_range(3) != 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
                   5'($urandom_range(3)), $urandom, $urandom, 8'($urandom));
            id_imm_i       = $urandom;
            wb_reg_write_i = $urandom_range(1);
            wb_rd_addr_i   = 5'($urandom_range(3));
            wb_rd_data_i   = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline stage between the register-file read (ID) and execute (EX) in the 5-stage MIPS core.
- Captures register-file read data, immediate and decoded control into EX-side registers.
- Bypasses same-cycle writeback data into captured operands.
- Detects load-use hazards, inserts exactly one bubble, and honours flush (taken branch) and downstream stall.

Parameters:
- DATA_W, 32, operand/immediate width
- ADDR_W, 5, register address width
- CTRL_W, 8, packed control bundle width (field layout from cpu_pkg)

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs_addr_i, id_rt_addr_i, id_rd_addr_i  in  ADDR_W each  source/destination addresses
- id_rs_data_i, id_rt_data_i  in  DATA_W each  register-file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_ctrl_i  in  CTRL_W  control bundle; bit CTRL_MEM_READ marks a load, bit CTRL_REG_WRITE marks a write
- wb_reg_write_i  in  1  writeback enable (same strobe fed to register file)
- wb_rd_addr_i  in  ADDR_W  writeback address
- wb_rd_data_i  in  DATA_W  writeback data
- flush_i  in  1  squash instruction entering EX (taken branch/jump)
- ex_stall_i  in  1  EX/MEM backpressure; hold stage contents
- id_stall_o  out  1  freeze PC and IF/ID this cycle
- ex_valid_o  out  1  EX entry valid
- ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o  out  ADDR_W each
- ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DATA_W each
- ex_ctrl_o  out  CTRL_W  control; forced to 0 for bubbles

Behaviour:
- Reset: all ex_* outputs 0, ex_valid_o 0, id_stall_o 0, FSM in S_RUN. Reset mid-hazard returns to S_RUN.
- Latency: one cycle, ID capture at posedge N, visible on ex_* after posedge N.
- Hazard (combinational): ex_valid_o & ex_ctrl_o[CTRL_MEM_READ] & ex_rd_addr_o!=0 & id_valid_i & (id_rs_addr_i==ex_rd_addr_o | id_rt_addr_i==ex_rd_addr_o). Comparison is conservative: rt is always compared.
- FSM S_RUN:
  - hazard: id_stall_o=1, load bubble (ex_valid_o=0, ex_ctrl_o=0), go to S_HAZ.
  - otherwise: capture ID.
- FSM S_HAZ: id_stall_o=0, capture ID (the stalled instruction), return to S_RUN. Exactly one bubble per load-use.
- Priority per cycle: rst_i > flush_i > ex_stall_i > hazard > capture.
  - flush_i: load bubble, FSM to S_RUN, id_stall_o=0. Flush wins over ex_stall_i.
  - ex_stall_i (no flush): hold all ex_* unchanged, FSM holds, id_stall_o=1.
- Bypass on capture:
  - If wb_reg_write_i & wb_rd_addr_i!=0 & wb_rd_addr_i==id_rs_addr_i, capture wb_rd_data_i into ex_rs_data_o; same rule for rt.
  - Both sources may bypass in the same cycle.
  - Register 0 never bypasses and never triggers a hazard.
- Held entries (ex_stall_i) are not re-bypassed; downstream forwarding covers them.
- id_valid_i=0 on capture loads a bubble. Captured fields are don't-care but driven to 0.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubble_cnt_o[15:0] (load-use bubbles) and perf_flush_cnt_o[15:0] (flushes that squashed a valid ID instruction).
  - Counters saturate at 16'hFFFF, reset to 0, and increment once per event cycle; ex_stall_i cycles are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- cpu_pkg: DATA_W/ADDR_W defaults, CTRL_W, control bit indices (CTRL_REG_WRITE, CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_MEM_TO_REG, CTRL_ALU_SRC, CTRL_ALU_OP range), FSM state encoding (S_RUN, S_HAZ).
- One sub-module: id_ex_hazard_detect, purely combinational hazard compare, reused later by the branch-compare logic in ID.

Test Plan:
- Reset then plain capture: rst_i 2 cycles, then id rs=3 data 0x11, rt=4 data 0x22, ctrl 0x81 -> next cycle ex_valid_o=1, ex_rs_data_o=0x11, ex_rt_data_o=0x22; during reset all outputs 0.
- WB bypass: id rs=5 data 0xDEAD with wb_reg_write_i=1, wb_rd_addr_i=5, wb data 0x1234 -> ex_rs_data_o=0x1234. Repeat with address 0 -> 0xDEAD kept.
- Load-use: EX holds load rd=7; ID rt=7 -> id_stall_o=1 one cycle, one bubble (ex_ctrl_o=0). Next cycle the dependent instruction captured; bubble counter (if enabled) =1.
- Flush during hazard: hazard cycle with flush_i=1 -> bubble, id_stall_o=0, FSM S_RUN next cycle, no second bubble.
- Downstream stall: ex_stall_i high 3 cycles with new ID data presented -> ex_* unchanged, id_stall_o=1 for all 3, capture on the 4th cycle.
- Counter saturation (IDEX_PERF_CNT_EN): preload/force 0xFFFE, two more bubbles -> perf_bubble_cnt_o=0xFFFF, stays there.
